// File: rtl/tdc_therm_decoder.sv
// TDC thermometer decoder: captures the delay-line word on a start strobe,
// removes single-bit bubbles with a 3-tap majority filter and reports the popcount.
module tdc_therm_decoder #(
  parameter int N     = 64,
  parameter int OUT_W = $clog2(N+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     dl_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] count_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             bubble_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    CORRECT = 3'd2,
    COUNT   = 3'd3,
    VALID   = 3'd4
  } state_t;

  state_t           state;
  logic [N-1:0]     raw;
  logic [N-1:0]     corr;
  logic             bubble_r;
  logic [N-1:0]     maj;
  logic [N+1:0]     ext;
  logic [OUT_W-1:0] pop;

  // Virtual taps: one before the line is always 1, one past the end is always 0.
  assign ext = {1'b0, raw, 1'b1};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_maj
      assign maj[gi] = (ext[gi] & ext[gi+1]) |
                       (ext[gi] & ext[gi+2]) |
                       (ext[gi+1] & ext[gi+2]);
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + OUT_W'(corr[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      raw      <= '0;
      corr     <= '0;
      bubble_r <= 1'b0;
      count_o  <= '0;
      ovf_o    <= 1'b0;
      zero_o   <= 1'b0;
      bubble_o <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= CAPTURE;
            busy_o <= 1'b1;
          end
        end
        CAPTURE: begin
          raw   <= dl_i;
          state <= CORRECT;
        end
        CORRECT: begin
          corr     <= maj;
          bubble_r <= (maj != raw);
          state    <= COUNT;
        end
        COUNT: begin
          count_o  <= pop;
          ovf_o    <= &corr;
          zero_o   <= ~|corr;
          bubble_o <= bubble_r;
          valid_o  <= 1'b1;
          state    <= VALID;
        end
        VALID: begin
          // Result fields stay as they are after the handshake until the next COUNT.
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
